// File: rtl/axil_mem_pkg.sv
// rtl/axil_mem_pkg.sv - shared response codes, write-FSM states and byte-strobe merge for axil_mem_responder.
package axil_mem_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      W_IDLE    = 2'd0,
      W_HAVE_AW = 2'd1,
      W_HAVE_W  = 2'd2,
      W_RESP    = 2'd3
   } wstate_t;

   function automatic logic [31:0] strb_merge(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  strb);
      logic [31:0] res;
      for (int b = 0; b < 4; b++) begin
         res[b*8 +: 8] = strb[b] ? new_word[b*8 +: 8] : old_word[b*8 +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/axil_mem_sdp_ram.sv
// rtl/axil_mem_sdp_ram.sv - simple dual-port RAM, byte-enabled write port, registered read-before-write port.
module axil_mem_sdp_ram
   import axil_mem_pkg::*;
#(
   parameter int DEPTH = 256,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_we,
   input  logic [3:0]    i_be,
   input  logic [AW-1:0] i_waddr,
   input  logic [31:0]   i_wdata,
   input  logic          i_re,
   input  logic [AW-1:0] i_raddr,
   output logic [31:0]   o_rdata
);

   logic [31:0] r_mem [DEPTH];
   logic [31:0] r_rdata;

   // Array is deliberately not reset so contents survive a bus reset.
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= strb_merge(r_mem[i_waddr], i_wdata, i_be);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rdata <= '0;
      end else if (i_re) begin
         r_rdata <= r_mem[i_raddr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/axil_mem_responder.sv
// rtl/axil_mem_responder.sv - AXI4-Lite slave memory with byte strobes and independent read/write channels.
// Optional AXIL_MEM_RANGE_CHECK_EN: out-of-range accesses get SLVERR instead of aliasing modulo depth.
module axil_mem_responder
   import axil_mem_pkg::*;
#(
   parameter int                    ADDR_WIDTH  = 32,
   parameter int                    DATA_WIDTH  = 32,
   parameter int                    DEPTH_WORDS = 256,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0
) (
   input  logic                    S_AXI_ACLK,
   input  logic                    S_AXI_ARESETN,
   input  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic [2:0]              S_AXI_AWPROT,
   input  logic                    S_AXI_AWVALID,
   output logic                    S_AXI_AWREADY,
   input  logic [DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                    S_AXI_WVALID,
   output logic                    S_AXI_WREADY,
   output logic [1:0]              S_AXI_BRESP,
   output logic                    S_AXI_BVALID,
   input  logic                    S_AXI_BREADY,
   input  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic [2:0]              S_AXI_ARPROT,
   input  logic                    S_AXI_ARVALID,
   output logic                    S_AXI_ARREADY,
   output logic [DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]              S_AXI_RRESP,
   output logic                    S_AXI_RVALID,
   input  logic                    S_AXI_RREADY
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);

   wstate_t                 r_wstate;
   logic                    r_awready;
   logic                    r_wready;
   logic                    r_bvalid;
   logic [1:0]              r_bresp;
   logic [ADDR_WIDTH-1:0]   r_awaddr;
   logic [DATA_WIDTH-1:0]   r_wdata;
   logic [DATA_WIDTH/8-1:0] r_wstrb;
   logic                    r_arready;
   logic                    r_rvalid;
   logic [1:0]              r_rresp;

   logic                    w_aw_hs;
   logic                    w_w_hs;
   logic                    w_ar_hs;
   logic                    w_commit;
   logic [ADDR_WIDTH-1:0]   w_wr_addr;
   logic [DATA_WIDTH-1:0]   w_wr_data;
   logic [DATA_WIDTH/8-1:0] w_wr_strb;
   logic [ADDR_WIDTH-1:0]   w_wr_off;
   logic [ADDR_WIDTH-1:0]   w_rd_off;
   logic [IDX_W-1:0]        w_wr_idx;
   logic [IDX_W-1:0]        w_rd_idx;
   logic                    w_wr_err;
   logic                    w_rd_err;
   logic                    w_ram_we;
   logic                    w_rvalid_nxt;
   logic [31:0]             w_ram_rdata;
   logic                    w_unused;

   assign w_aw_hs = S_AXI_AWVALID && r_awready;
   assign w_w_hs  = S_AXI_WVALID  && r_wready;
   assign w_ar_hs = S_AXI_ARVALID && r_arready;

   assign w_commit = ((r_wstate == W_IDLE) && w_aw_hs && w_w_hs) ||
                     ((r_wstate == W_HAVE_AW) && w_w_hs) ||
                     ((r_wstate == W_HAVE_W)  && w_aw_hs);

   // Whichever half arrived first comes from the holding register.
   assign w_wr_addr = (r_wstate == W_HAVE_AW) ? r_awaddr : S_AXI_AWADDR;
   assign w_wr_data = (r_wstate == W_HAVE_W)  ? r_wdata  : S_AXI_WDATA;
   assign w_wr_strb = (r_wstate == W_HAVE_W)  ? r_wstrb  : S_AXI_WSTRB;

   assign w_wr_off = w_wr_addr - BASE_ADDR;
   assign w_rd_off = S_AXI_ARADDR - BASE_ADDR;
   assign w_wr_idx = w_wr_off[IDX_W+1:2];
   assign w_rd_idx = w_rd_off[IDX_W+1:2];

`ifdef AXIL_MEM_RANGE_CHECK_EN
   localparam logic [ADDR_WIDTH-1:0] LP_SPAN = ADDR_WIDTH'(4 * DEPTH_WORDS);
   // Addresses below BASE_ADDR wrap to large offsets, so one compare covers both ends.
   assign w_wr_err = (w_wr_off >= LP_SPAN);
   assign w_rd_err = (w_rd_off >= LP_SPAN);
`else
   assign w_wr_err = 1'b0;
   assign w_rd_err = 1'b0;
`endif

   assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, w_wr_off, w_rd_off};

   assign w_ram_we = w_commit && !w_wr_err;

   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         r_wstate  <= W_IDLE;
         r_awready <= 1'b0;
         r_wready  <= 1'b0;
         r_bvalid  <= 1'b0;
         r_bresp   <= RESP_OKAY;
         r_awaddr  <= '0;
         r_wdata   <= '0;
         r_wstrb   <= '0;
      end else begin
         case (r_wstate)
            W_IDLE: begin
               if (w_aw_hs && w_w_hs) begin
                  r_wstate  <= W_RESP;
                  r_awready <= 1'b0;
                  r_wready  <= 1'b0;
                  r_bvalid  <= 1'b1;
                  r_bresp   <= w_wr_err ? RESP_SLVERR : RESP_OKAY;
               end else if (w_aw_hs) begin
                  r_wstate  <= W_HAVE_AW;
                  r_awaddr  <= S_AXI_AWADDR;
                  r_awready <= 1'b0;
                  r_wready  <= 1'b1;
               end else if (w_w_hs) begin
                  r_wstate  <= W_HAVE_W;
                  r_wdata   <= S_AXI_WDATA;
                  r_wstrb   <= S_AXI_WSTRB;
                  r_awready <= 1'b1;
                  r_wready  <= 1'b0;
               end else begin
                  r_awready <= 1'b1;
                  r_wready  <= 1'b1;
               end
            end
            W_HAVE_AW: begin
               if (w_w_hs) begin
                  r_wstate <= W_RESP;
                  r_wready <= 1'b0;
                  r_bvalid <= 1'b1;
                  r_bresp  <= w_wr_err ? RESP_SLVERR : RESP_OKAY;
               end
            end
            W_HAVE_W: begin
               if (w_aw_hs) begin
                  r_wstate  <= W_RESP;
                  r_awready <= 1'b0;
                  r_bvalid  <= 1'b1;
                  r_bresp   <= w_wr_err ? RESP_SLVERR : RESP_OKAY;
               end
            end
            W_RESP: begin
               if (S_AXI_BREADY) begin
                  r_wstate  <= W_IDLE;
                  r_bvalid  <= 1'b0;
                  r_awready <= 1'b1;
                  r_wready  <= 1'b1;
               end
            end
            default: begin
               r_wstate <= W_IDLE;
            end
         endcase
      end
   end

   assign w_rvalid_nxt = w_ar_hs || (r_rvalid && !S_AXI_RREADY);

   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         r_rvalid  <= 1'b0;
         r_rresp   <= RESP_OKAY;
         r_arready <= 1'b0;
      end else begin
         if (w_ar_hs) begin
            r_rvalid <= 1'b1;
            r_rresp  <= w_rd_err ? RESP_SLVERR : RESP_OKAY;
         end else if (r_rvalid && S_AXI_RREADY) begin
            r_rvalid <= 1'b0;
         end
         r_arready <= !w_rvalid_nxt;
      end
   end

   axil_mem_sdp_ram #(
      .DEPTH (DEPTH_WORDS)
   ) u_ram (
      .i_clk   (S_AXI_ACLK),
      .i_rst_n (S_AXI_ARESETN),
      .i_we    (w_ram_we),
      .i_be    (w_wr_strb),
      .i_waddr (w_wr_idx),
      .i_wdata (w_wr_data),
      .i_re    (w_ar_hs),
      .i_raddr (w_rd_idx),
      .o_rdata (w_ram_rdata)
   );

   assign S_AXI_AWREADY = r_awready;
   assign S_AXI_WREADY  = r_wready;
   assign S_AXI_BVALID  = r_bvalid;
   assign S_AXI_BRESP   = r_bresp;
   assign S_AXI_ARREADY = r_arready;
   assign S_AXI_RVALID  = r_rvalid;
   assign S_AXI_RRESP   = r_rresp;
   assign S_AXI_RDATA   = (r_rresp == RESP_SLVERR) ? '0 : w_ram_rdata;

endmodule

// File: tb/tb_axil_mem_responder.sv
// tb/tb_axil_mem_responder.sv - directed scoreboard bench for axil_mem_responder.
module tb_axil_mem_responder;
   import axil_mem_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] awaddr = '0;
   logic [2:0]  awprot = '0;
   logic        awvalid = 1'b0;
   logic        awready;
   logic [31:0] wdata = '0;
   logic [3:0]  wstrb = '0;
   logic        wvalid = 1'b0;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready = 1'b1;
   logic [31:0] araddr = '0;
   logic [2:0]  arprot = '0;
   logic        arvalid = 1'b0;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready = 1'b1;

   int errors = 0;
   int checks = 0;

   logic [31:0] rq_data[$];
   logic [1:0]  rq_resp[$];
   logic [1:0]  bq[$];
   logic        aw_f, w_f, ar_f, r_f, b_f;
   logic [31:0] arr[8];

   axil_mem_responder dut (
      .S_AXI_ACLK    (clk),
      .S_AXI_ARESETN (rst_n),
      .S_AXI_AWADDR  (awaddr),
      .S_AXI_AWPROT  (awprot),
      .S_AXI_AWVALID (awvalid),
      .S_AXI_AWREADY (awready),
      .S_AXI_WDATA   (wdata),
      .S_AXI_WSTRB   (wstrb),
      .S_AXI_WVALID  (wvalid),
      .S_AXI_WREADY  (wready),
      .S_AXI_BRESP   (bresp),
      .S_AXI_BVALID  (bvalid),
      .S_AXI_BREADY  (bready),
      .S_AXI_ARADDR  (araddr),
      .S_AXI_ARPROT  (arprot),
      .S_AXI_ARVALID (arvalid),
      .S_AXI_ARREADY (arready),
      .S_AXI_RDATA   (rdata),
      .S_AXI_RRESP   (rresp),
      .S_AXI_RVALID  (rvalid),
      .S_AXI_RREADY  (rready)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog expired before the summary");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // One clock: sample handshakes at negedge, score R/B beats, retire accepted VALIDs after the edge.
   task automatic step();
      logic [31:0] ed;
      logic [1:0]  er;
      @(negedge clk);
      aw_f = awvalid && awready;
      w_f  = wvalid && wready;
      ar_f = arvalid && arready;
      r_f  = rvalid && rready;
      b_f  = bvalid && bready;
      if (r_f) begin
         checks++;
         assert (rq_data.size() != 0) else begin
            errors++;
            $error("FAIL r_unexpected observed=beat expected=none");
         end
         if (rq_data.size() != 0) begin
            ed = rq_data.pop_front();
            er = rq_resp.pop_front();
            check("rdata", rdata, ed);
            check("rresp", 32'(rresp), 32'(er));
         end
      end
      if (b_f) begin
         checks++;
         assert (bq.size() != 0) else begin
            errors++;
            $error("FAIL b_unexpected observed=beat expected=none");
         end
         if (bq.size() != 0) begin
            er = bq.pop_front();
            check("bresp", 32'(bresp), 32'(er));
         end
      end
      @(posedge clk);
      #1;
      if (aw_f) awvalid = 1'b0;
      if (w_f)  wvalid  = 1'b0;
      if (ar_f) arvalid = 1'b0;
   endtask

   task automatic drain(input int limit);
      int n = 0;
      while ((bq.size() + rq_data.size()) != 0 && n < limit) begin
         step();
         n++;
      end
      check("drain_empty", 32'(bq.size() + rq_data.size()), 32'd0);
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                     input int aw_dly, input int w_dly, input logic [1:0] exp_resp);
      logic aw_done = 1'b0;
      logic w_done  = 1'b0;
      int   n = 0;
      bq.push_back(exp_resp);
      for (int c = 0; c < 30; c++) begin
         if (c == aw_dly) begin awaddr = a; awvalid = 1'b1; end
         if (c == w_dly)  begin wdata = d; wstrb = s; wvalid = 1'b1; end
         step();
         if (aw_f) aw_done = 1'b1;
         if (w_f)  w_done  = 1'b1;
         if (aw_done && w_done) break;
         if (w_done)  check("have_w_ready",  32'({awready, wready}), 32'd2);
         if (aw_done) check("have_aw_ready", 32'({awready, wready}), 32'd1);
      end
      while (bq.size() != 0 && n < 20) begin
         step();
         n++;
      end
      check("b_latency", 32'(n), 32'd1);
   endtask

   task automatic rd(input logic [31:0] a, input logic [31:0] exp_d, input logic [1:0] exp_r);
      int n = 0;
      rq_data.push_back(exp_d);
      rq_resp.push_back(exp_r);
      araddr  = a;
      arvalid = 1'b1;
      while (rq_data.size() != 0 && n < 20) begin
         step();
         n++;
      end
      check("r_latency", 32'(n), 32'd2);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("rst_readies", 32'({awready, wready, arready}), 32'd0);
      check("rst_valids",  32'({bvalid, rvalid}), 32'd0);
      check("rst_resps",   32'({bresp, rresp}), 32'd0);
      check("rst_rdata",   rdata, 32'd0);
      rst_n = 1'b1;
      step();
      check("post_rst_readies", 32'({awready, wready, arready}), 32'd7);

      wr(32'h40, 32'hDEADBEEF, 4'hF, 0, 0, RESP_OKAY);
      rd(32'h40, 32'hDEADBEEF, RESP_OKAY);

      wr(32'h44, 32'h0BADCAFE, 4'hF, 2, 0, RESP_OKAY);
      rd(32'h44, 32'h0BADCAFE, RESP_OKAY);
      wr(32'h44, 32'h12345678, 4'hF, 0, 2, RESP_OKAY);
      rd(32'h44, 32'h12345678, RESP_OKAY);

      wr(32'h48, 32'h11223344, 4'hF, 0, 0, RESP_OKAY);
      wr(32'h48, 32'h000000AA, 4'b0001, 0, 0, RESP_OKAY);
      rd(32'h48, 32'h112233AA, RESP_OKAY);
      wr(32'h48, 32'hFFFFFFFF, 4'b0000, 1, 0, RESP_OKAY);
      rd(32'h48, 32'h112233AA, RESP_OKAY);
      wr(32'h48, 32'h55AA0000, 4'b1100, 0, 0, RESP_OKAY);
      rd(32'h48, 32'h55AA33AA, RESP_OKAY);

      // Back-pressure on both response channels.
      bready = 1'b0;
      rready = 1'b0;
      awaddr = 32'h50; wdata = 32'hCAFEF00D; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
      araddr = 32'h40; arvalid = 1'b1;
      bq.push_back(RESP_OKAY);
      rq_data.push_back(32'hDEADBEEF);
      rq_resp.push_back(RESP_OKAY);
      step();
      for (int k = 0; k < 5; k++) begin
         step();
         check("stall_valids",  32'({bvalid, rvalid}), 32'd3);
         check("stall_rdata",   rdata, 32'hDEADBEEF);
         check("stall_bresp",   32'(bresp), 32'd0);
         check("stall_readies", 32'({awready, wready, arready}), 32'd0);
      end
      bready = 1'b1;
      rready = 1'b1;
      drain(10);
      rd(32'h50, 32'hCAFEF00D, RESP_OKAY);

      // Same-cycle read and write of one word returns the old contents.
      wr(32'h60, 32'h01010101, 4'hF, 0, 0, RESP_OKAY);
      awaddr = 32'h60; wdata = 32'h02020202; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
      araddr = 32'h60; arvalid = 1'b1;
      bq.push_back(RESP_OKAY);
      rq_data.push_back(32'h01010101);
      rq_resp.push_back(RESP_OKAY);
      drain(10);
      rd(32'h60, 32'h02020202, RESP_OKAY);

      for (int i = 0; i < 8; i++) begin
         arr[i] = $urandom;
         wr(32'h80 + 32'(4 * i), arr[i], 4'hF, i % 3, (2 * i) % 3, RESP_OKAY);
      end
      for (int i = 0; i < 8; i++) begin
         rd(32'h80 + 32'(4 * i), arr[i], RESP_OKAY);
      end

      // Range edges: last word, and one past the end.
      wr(32'h0, 32'h0BADF00D, 4'hF, 0, 0, RESP_OKAY);
      wr(32'h4, 32'h77777777, 4'hF, 0, 0, RESP_OKAY);
      wr(32'h3FC, 32'hA5A5A5A5, 4'hF, 0, 0, RESP_OKAY);
      rd(32'h3FC, 32'hA5A5A5A5, RESP_OKAY);
`ifdef AXIL_MEM_RANGE_CHECK_EN
      rd(32'h400, 32'h0, RESP_SLVERR);
      wr(32'h404, 32'h55555555, 4'hF, 0, 0, RESP_SLVERR);
      rd(32'h4, 32'h77777777, RESP_OKAY);
`else
      rd(32'h400, 32'h0BADF00D, RESP_OKAY);
      wr(32'h404, 32'h55555555, 4'hF, 0, 0, RESP_OKAY);
      rd(32'h4, 32'h55555555, RESP_OKAY);
`endif

      // Reset while a read response is outstanding.
      rready  = 1'b0;
      araddr  = 32'h40;
      arvalid = 1'b1;
      step();
      check("pre_rst_rvalid", 32'(rvalid), 32'd1);
      rst_n = 1'b0;
      #1;
      check("async_rst_rvalid", 32'(rvalid), 32'd0);
      check("async_rst_readies", 32'({awready, wready, arready}), 32'd0);
      arvalid = 1'b0;
      rready  = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step();
      check("rerst_readies", 32'({awready, wready, arready}), 32'd7);
      rd(32'h40, 32'hDEADBEEF, RESP_OKAY);
      rd(32'h48, 32'h55AA33AA, RESP_OKAY);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
